// File: rtl/umi_xbar_pkg.sv
// Shared UMI crossbar definitions: default field geometry, destination-ID
// decode, and the buffered entry layout used by the ingress stages.
package umi_xbar_pkg;

    localparam int UMI_CW    = 32;
    localparam int UMI_AW    = 64;
    localparam int UMI_DW    = 256;
    localparam int UMI_IDLSB = 40;
    localparam int UMI_IDW   = 16;

    // Entry layout at the default widths; the ingress keeps the same field
    // order when instantiated with other widths.
    typedef struct packed {
        logic [UMI_CW-1:0]  cmd;
        logic [UMI_AW-1:0]  dstaddr;
        logic [UMI_AW-1:0]  srcaddr;
        logic [UMI_DW-1:0]  data;
        logic [UMI_IDW-1:0] id;
    } umi_entry_t;

    function automatic logic [UMI_IDW-1:0] umi_dst_id(input logic [UMI_AW-1:0] dstaddr);
        return dstaddr[UMI_IDLSB+:UMI_IDW];
    endfunction

endpackage

// File: rtl/umi_xbar_fifo2.sv
// Generic 2-entry circular FIFO with 1-bit pointers and a 2-bit occupancy
// count; the head entry is read combinationally from registered storage.
module umi_xbar_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count,
    output logic         empty,
    output logic         full
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: non-blocking assignments keep every register update in this block
    // based on pre-edge values, so pointer and count updates cannot race.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            if (do_push && !do_pop)      count <= count + 2'd1;
            else if (!do_push && do_pop) count <= count - 2'd1;
        end
    end

    // NOTE: payload storage is deliberately not reset; count==0 already marks
    // every slot invalid, and skipping the reset keeps the wide data path lean.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/umi_xbar_ingress.sv
// Per-port crossbar ingress: buffers UMI transactions, decodes the destination
// port and raises a stable one-hot request; unroutable entries are dropped.
module umi_xbar_ingress
    import umi_xbar_pkg::*;
#(
    parameter int N     = 4,
    parameter int CW    = UMI_CW,
    parameter int AW    = UMI_AW,
    parameter int DW    = UMI_DW,
    parameter int IDLSB = UMI_IDLSB,
    parameter int IDW   = UMI_IDW,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            umi_in_valid,
    output logic            umi_in_ready,
    input  logic [CW-1:0]   umi_in_cmd,
    input  logic [AW-1:0]   umi_in_dstaddr,
    input  logic [AW-1:0]   umi_in_srcaddr,
    input  logic [DW-1:0]   umi_in_data,
    output logic [N-1:0]    xbar_request,
    output logic [CW-1:0]   xbar_cmd,
    output logic [AW-1:0]   xbar_dstaddr,
    output logic [AW-1:0]   xbar_srcaddr,
    output logic [DW-1:0]   xbar_data,
    input  logic            xbar_ready,
    output logic            drop_pulse,
    output logic [CNTW-1:0] drop_count
);

    typedef struct packed {
        logic [CW-1:0]  cmd;
        logic [AW-1:0]  dstaddr;
        logic [AW-1:0]  srcaddr;
        logic [DW-1:0]  data;
        logic [IDW-1:0] id;
    } entry_t;

    entry_t         wr_entry;
    entry_t         head;
    logic [IDW-1:0] in_id;
    logic [1:0]     fifo_count;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;
    logic           head_hit;

    // Decode once at push time so the head's request is a pure function of
    // stored state and never depends on the upstream interface.
    if (AW == UMI_AW && IDLSB == UMI_IDLSB && IDW == UMI_IDW) begin : g_pkg_id
        assign in_id = umi_dst_id(umi_in_dstaddr);
    end else begin : g_param_id
        assign in_id = umi_in_dstaddr[IDLSB+:IDW];
    end

    assign wr_entry = '{cmd:     umi_in_cmd,
                        dstaddr: umi_in_dstaddr,
                        srcaddr: umi_in_srcaddr,
                        data:    umi_in_data,
                        id:      in_id};

    // Ready looks only at registered occupancy: a full FIFO refuses a push
    // even when the head leaves in the same cycle.
    assign umi_in_ready = ~fifo_full;
    assign push         = umi_in_valid & umi_in_ready;

    assign head_hit     = ~fifo_empty & (head.id < IDW'(N));
    assign drop_pulse   = ~fifo_empty & ~head_hit;
    assign xbar_request = head_hit ? (N'(1) << head.id) : '0;
    assign pop          = (xbar_ready & head_hit) | drop_pulse;

    assign xbar_cmd     = head.cmd;
    assign xbar_dstaddr = head.dstaddr;
    assign xbar_srcaddr = head.srcaddr;
    assign xbar_data    = head.data;

    umi_xbar_fifo2 #(
        .W($bits(entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (reset)
            drop_count <= '0;
        else if (drop_pulse && (drop_count != '1))
            drop_count <= drop_count + CNTW'(1);
    end

endmodule

// File: tb/tb_umi_xbar_ingress.sv
// Scoreboard bench for umi_xbar_ingress: expected head entries are queued at
// accept and checked when the crossbar side takes them.
module tb_umi_xbar_ingress;

    localparam int N     = 4;
    localparam int CW    = 32;
    localparam int AW    = 64;
    localparam int DW    = 256;
    localparam int IDLSB = 40;
    localparam int IDW   = 16;
    localparam int CNTW  = 2;

    logic            clk;
    logic            reset;
    logic            umi_in_valid;
    logic            umi_in_ready;
    logic [CW-1:0]   umi_in_cmd;
    logic [AW-1:0]   umi_in_dstaddr;
    logic [AW-1:0]   umi_in_srcaddr;
    logic [DW-1:0]   umi_in_data;
    logic [N-1:0]    xbar_request;
    logic [CW-1:0]   xbar_cmd;
    logic [AW-1:0]   xbar_dstaddr;
    logic [AW-1:0]   xbar_srcaddr;
    logic [DW-1:0]   xbar_data;
    logic            xbar_ready;
    logic            drop_pulse;
    logic [CNTW-1:0] drop_count;

    umi_xbar_ingress #(
        .N(N), .CW(CW), .AW(AW), .DW(DW), .IDLSB(IDLSB), .IDW(IDW), .CNTW(CNTW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .umi_in_valid   (umi_in_valid),
        .umi_in_ready   (umi_in_ready),
        .umi_in_cmd     (umi_in_cmd),
        .umi_in_dstaddr (umi_in_dstaddr),
        .umi_in_srcaddr (umi_in_srcaddr),
        .umi_in_data    (umi_in_data),
        .xbar_request   (xbar_request),
        .xbar_cmd       (xbar_cmd),
        .xbar_dstaddr   (xbar_dstaddr),
        .xbar_srcaddr   (xbar_srcaddr),
        .xbar_data      (xbar_data),
        .xbar_ready     (xbar_ready),
        .drop_pulse     (drop_pulse),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  req;
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   pop_count = 0;
    int   drop_seen = 0;
    int   seq       = 0;
    exp_t mon_e;

    function automatic logic [CW-1:0] mk_cmd(input int s);
        return 32'hC000_0000 | 32'(s);
    endfunction

    function automatic logic [AW-1:0] mk_dst(input logic [15:0] id, input int s);
        logic [AW-1:0] d;
        d = {8'hA5, id, 40'(s)};
        return d;
    endfunction

    function automatic logic [AW-1:0] mk_src(input int s);
        return {32'h5A5A_0000 | 32'(s), 32'(s * 3)};
    endfunction

    function automatic logic [DW-1:0] mk_data(input int s);
        return {8{32'(s) ^ 32'hDEAD_BEEF}};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Crossbar-side monitor: a request seen with xbar_ready set is taken at
    // the next edge, so it must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (drop_pulse) drop_seen++;
            if (xbar_ready && (xbar_request != '0)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_unexpected: got req=%b dst=%h, required no request", xbar_request, xbar_dstaddr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (xbar_request !== mon_e.req || xbar_cmd !== mon_e.cmd || xbar_dstaddr !== mon_e.dst ||
                        xbar_srcaddr !== mon_e.src || xbar_data !== mon_e.data) begin
                        n_fail++;
                        $display("FAIL pop_entry: got req=%b cmd=%h dst=%h src=%h, required req=%b cmd=%h dst=%h src=%h data_ok=%0d",
                                 xbar_request, xbar_cmd, xbar_dstaddr, xbar_srcaddr,
                                 mon_e.req, mon_e.cmd, mon_e.dst, mon_e.src, xbar_data === mon_e.data);
                    end
                end
                pop_count++;
                pop_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic drive_fields(input logic [15:0] id, input int s);
        umi_in_cmd     = mk_cmd(s);
        umi_in_dstaddr = mk_dst(id, s);
        umi_in_srcaddr = mk_src(s);
        umi_in_data    = mk_data(s);
    endtask

    task automatic expect_entry(input logic [15:0] id, input int s);
        exp_t e;
        logic [N-1:0] one;
        one    = 1;
        e.req  = one << id;
        e.cmd  = mk_cmd(s);
        e.dst  = mk_dst(id, s);
        e.src  = mk_src(s);
        e.data = mk_data(s);
        if (id < 16'(N)) exp_q.push_back(e);
    endtask

    // Offers one transaction and returns #1 after the accepting edge.
    task automatic push_txn(input logic [15:0] id, output int s, output int waits);
        int w;
        s = seq;
        seq++;
        w = 0;
        drive_fields(id, s);
        umi_in_valid = 1'b1;
        @(negedge clk);
        while (!umi_in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        waits = w;
        if (!umi_in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: got umi_in_ready=0 for %0d cycles, required 1", w);
            umi_in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        expect_entry(id, s);
        #1 umi_in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d entries outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        umi_in_valid = 1'b0;
        xbar_ready   = 1'b0;
        drive_fields(16'd0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_checks += 4;
        if (umi_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", umi_in_ready); end
        if (xbar_request !== '0) begin n_fail++; $display("FAIL reset_request: got %b required 0000", xbar_request); end
        if (drop_count !== '0) begin n_fail++; $display("FAIL reset_drop_count: got %0d required 0", drop_count); end
        if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_drop_pulse: got %b required 0", drop_pulse); end
    endtask

    task automatic test_single;
        int s;
        xbar_ready = 1'b1;
        s = seq;
        seq++;
        drive_fields(16'd2, s);
        umi_in_valid = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (xbar_request !== '0) begin n_fail++; $display("FAIL single_pre_request: got %b required 0000", xbar_request); end
        if (umi_in_ready !== 1'b1) begin n_fail++; $display("FAIL single_pre_ready: got %b required 1", umi_in_ready); end
        @(posedge clk);
        expect_entry(16'd2, s);
        #1 umi_in_valid = 1'b0;
        n_checks += 2;
        if (xbar_request !== 4'b0100) begin n_fail++; $display("FAIL single_request: got %b required 0100", xbar_request); end
        if (umi_in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b required 1", umi_in_ready); end
        @(posedge clk);
        #1;
        n_checks += 2;
        if (xbar_request !== '0) begin n_fail++; $display("FAIL single_post_request: got %b required 0000", xbar_request); end
        if (umi_in_ready !== 1'b1) begin n_fail++; $display("FAIL single_post_ready: got %b required 1", umi_in_ready); end
        wait_drain("single");
    endtask

    task automatic test_back_pressure;
        int s1, s3, w;
        xbar_ready = 1'b0;
        push_txn(16'd1, s1, w);
        push_txn(16'd3, s3, w);
        n_checks++;
        if (umi_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b required 0", umi_in_ready); end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (xbar_request !== 4'b0010 || xbar_dstaddr !== mk_dst(16'd1, s1) || xbar_cmd !== mk_cmd(s1)) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got req=%b dst=%h, required req=0010 dst=%h", i, xbar_request, xbar_dstaddr, mk_dst(16'd1, s1));
            end
            @(posedge clk);
            #1;
        end
        xbar_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (umi_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_at_pop: got %b required 0", umi_in_ready); end
        @(posedge clk);
        #1;
        n_checks += 2;
        if (umi_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b required 1", umi_in_ready); end
        if (xbar_request !== 4'b1000) begin n_fail++; $display("FAIL bp_second_request: got %b required 1000", xbar_request); end
        wait_drain("bp");
    endtask

    task automatic test_drop;
        int s, w, d0;
        xbar_ready = 1'b1;
        d0 = drop_seen;
        push_txn(16'd0, s, w);
        push_txn(16'd7, s, w);
        push_txn(16'd1, s, w);
        wait_drain("drop");
        n_checks += 2;
        if (drop_seen - d0 !== 1) begin n_fail++; $display("FAIL drop_pulses: got %0d required 1", drop_seen - d0); end
        if (drop_count !== 2'd1) begin n_fail++; $display("FAIL drop_count: got %0d required 1", drop_count); end
    endtask

    task automatic test_reset_mid;
        int s, w, d0;
        xbar_ready = 1'b0;
        push_txn(16'd2, s, w);
        push_txn(16'd1, s, w);
        n_checks += 2;
        if (xbar_request !== 4'b0100) begin n_fail++; $display("FAIL rmid_pre_request: got %b required 0100", xbar_request); end
        if (umi_in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_pre_ready: got %b required 0", umi_in_ready); end
        d0 = drop_seen;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        n_checks += 4;
        if (xbar_request !== '0) begin n_fail++; $display("FAIL rmid_request: got %b required 0000", xbar_request); end
        if (umi_in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b required 1", umi_in_ready); end
        if (drop_count !== '0) begin n_fail++; $display("FAIL rmid_drop_count: got %0d required 0", drop_count); end
        if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL rmid_drop_pulse: got %b required 0", drop_pulse); end
        xbar_ready = 1'b1;
        push_txn(16'd3, s, w);
        n_checks++;
        if (xbar_request !== 4'b1000) begin n_fail++; $display("FAIL rmid_first_request: got %b required 1000", xbar_request); end
        wait_drain("rmid");
        n_checks++;
        if (drop_seen !== d0) begin n_fail++; $display("FAIL rmid_no_drop: got %0d pulses required 0", drop_seen - d0); end
    endtask

    task automatic test_back_to_back;
        int s, w, total_waits, p0;
        xbar_ready  = 1'b1;
        total_waits = 0;
        p0          = pop_count;
        for (int i = 0; i < 100; i++) begin
            push_txn(16'(i % N), s, w);
            total_waits += w;
        end
        wait_drain("stream");
        n_checks += 2;
        if (total_waits !== 0) begin n_fail++; $display("FAIL stream_ready: got %0d stall cycles required 0", total_waits); end
        if (pop_count - p0 !== 100) begin
            n_fail++;
            $display("FAIL stream_pops: got %0d required 100", pop_count - p0);
        end else begin
            n_checks++;
            if (pop_cyc_q[p0 + 99] - pop_cyc_q[p0] !== 99) begin
                n_fail++;
                $display("FAIL stream_bubbles: got span %0d cycles required 99", pop_cyc_q[p0 + 99] - pop_cyc_q[p0]);
            end
        end
    endtask

    task automatic test_saturation;
        logic [15:0] ids [5];
        int s, w, d0;
        ids = '{16'd4, 16'd7, 16'd100, 16'hFFFF, 16'd5};
        xbar_ready = 1'b1;
        d0 = drop_seen;
        for (int i = 0; i < 5; i++) push_txn(ids[i], s, w);
        repeat (3) @(posedge clk);
        #1;
        n_checks += 4;
        if (drop_count !== 2'd3) begin n_fail++; $display("FAIL sat_count: got %0d required 3", drop_count); end
        if (drop_seen - d0 !== 5) begin n_fail++; $display("FAIL sat_pulses: got %0d required 5", drop_seen - d0); end
        if (xbar_request !== '0) begin n_fail++; $display("FAIL sat_request: got %b required 0000", xbar_request); end
        if (umi_in_ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready: got %b required 1", umi_in_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_pressure();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
